// File: rtl/serial_substractor_pkg.sv
// rtl/serial_substractor_pkg.sv - shared constants for the serial subtractor
//
// Purpose : default operand width and FSM state encodings shared by the
//           serial subtractor and its bench.
// Ports   : none (package).
package serial_substractor_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/full_substractor.sv
// rtl/full_substractor.sv - one-bit full subtractor
//
// Purpose : combinational a - b - borrow for a single bit.
// Ports   : a, b, borrow  - input bits
//           diff          - difference bit
//           borrow_out    - 1 when a < b + borrow
module full_substractor (
  input  logic a,
  input  logic b,
  input  logic borrow,
  output logic diff,
  output logic borrow_out
);

  assign diff       = a ^ b ^ borrow;
  // Borrow when a=0 and b=1, or when a==b and a borrow comes in.
  assign borrow_out = (~a & b) | (~(a ^ b) & borrow);

endmodule

// File: rtl/serial_substractor.sv
// rtl/serial_substractor.sv - bit-serial subtractor, one bit per clock
//
// Purpose : computes (a - b - borrow_in) mod 2^WIDTH LSB first, one
//           full-subtractor step per clock, with registered results.
// Ports   : clk        - clock, all state on rising edge
//           rst        - synchronous active-high reset
//           start      - begin a subtraction (accepted only in IDLE)
//           a, b       - minuend / subtrahend, captured on acceptance
//           borrow_in  - initial borrow, captured on acceptance
//           busy       - high while bits are being processed
//           done       - one-cycle pulse, diff/borrow_out just updated
//           diff       - registered result
//           borrow_out - registered final borrow
module serial_substractor
  import serial_substractor_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             borrow_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  state_t           r_state;
  state_t           w_state_next;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_res;
  logic             r_borrow;
  logic [CW-1:0]    r_count;
  logic [WIDTH-1:0] r_diff;
  logic             r_borrow_out;

  logic             w_load;
  logic             w_step;
  logic             w_last;
  logic             w_bit_diff;
  logic             w_bit_borrow;
  logic [WIDTH:0]   w_res_wide;
  logic [WIDTH-1:0] w_res_next;

  full_substractor u_bit (
    .a          (r_a[0]),
    .b          (r_b[0]),
    .borrow     (r_borrow),
    .diff       (w_bit_diff),
    .borrow_out (w_bit_borrow)
  );

  // Shift the new bit into the MSB; done through a WIDTH+1 vector so the
  // same expression is legal for WIDTH=1.
  assign w_res_wide = {w_bit_diff, r_res} >> 1;
  assign w_res_next = w_res_wide[WIDTH-1:0];
  assign w_last     = (r_count == LAST_BIT);

  always_comb begin
    w_state_next = r_state;
    w_load       = 1'b0;
    w_step       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_load       = 1'b1;
          w_state_next = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        w_step = 1'b1;
        if (w_last) begin
          w_state_next = ST_DONE;
        end
      end
      ST_DONE: begin
        w_state_next = ST_IDLE;
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_a          <= '0;
      r_b          <= '0;
      r_res        <= '0;
      r_borrow     <= 1'b0;
      r_count      <= '0;
      r_diff       <= '0;
      r_borrow_out <= 1'b0;
    end else if (w_load) begin
      r_a      <= a;
      r_b      <= b;
      r_res    <= '0;
      r_borrow <= borrow_in;
      r_count  <= '0;
    end else if (w_step) begin
      r_a      <= r_a >> 1;
      r_b      <= r_b >> 1;
      r_res    <= w_res_next;
      r_borrow <= w_bit_borrow;
      r_count  <= r_count + CW'(1);
      if (w_last) begin
        r_diff       <= w_res_next;
        r_borrow_out <= w_bit_borrow;
      end
    end
  end

  assign busy       = (r_state == ST_SHIFT);
  assign done       = (r_state == ST_DONE);
  assign diff       = r_diff;
  assign borrow_out = r_borrow_out;

endmodule

// File: doc/serial_substractor.md
SERIAL_SUBSTRACTOR -- requirements
Module: serial_substractor

Interface
REQ-001 The block SHALL have one parameter: WIDTH, default 8, operand and result width in bits (legal range 1..32).
REQ-002 Port clk  input  1  the only clock; all state SHALL update on its rising edge.
REQ-003 Port rst  input  1  synchronous, active-high reset, sampled only on the clk rising edge.
REQ-004 Port start  input  1  request to begin a subtraction, sampled on each rising edge.
REQ-005 Port a  input  WIDTH  minuend, captured when start is accepted.
REQ-006 Port b  input  WIDTH  subtrahend, captured when start is accepted.
REQ-007 Port borrow_in  input  1  initial borrow, captured when start is accepted.
REQ-008 Port busy  output  1  high while bits are being processed.
REQ-009 Port done  output  1  one-cycle pulse marking the result as valid.
REQ-010 Port diff  output  WIDTH  result (a - b - borrow_in) mod 2^WIDTH.
REQ-011 Port borrow_out  output  1  final borrow; 1 iff a < b + borrow_in (unsigned).

Function
REQ-012 The FSM SHALL have three states: IDLE, SHIFT and DONE.
REQ-013 In IDLE with start=1, the FSM SHALL load the operand shift registers from a and b, load the borrow flop from borrow_in, clear the bit counter and enter SHIFT.
REQ-014 At each edge in SHIFT, one full-subtractor step on (a_reg[0], b_reg[0], borrow_reg) SHALL shift its difference bit into the MSB of the result register, shift a_reg and b_reg right by one, load its borrow into borrow_reg and increment the counter.
REQ-015 The step that processes bit WIDTH-1 SHALL also move the FSM to DONE, copy the result register to diff and copy the final borrow to borrow_out.
REQ-016 Latency: if start is accepted at edge 0, bits are processed at edges 1..WIDTH and done SHALL be high for exactly the one cycle that follows edge WIDTH.
REQ-017 DONE SHALL return to IDLE unconditionally on the next edge.
REQ-018 busy SHALL be 1 exactly while in SHIFT; done SHALL be 1 exactly while in DONE.
REQ-019 start SHALL be ignored in SHIFT and DONE; the operands in flight SHALL NOT change.
REQ-020 diff and borrow_out SHALL hold their last values until the next completion; they SHALL NOT change while busy.
REQ-021 A start in the first IDLE cycle after DONE SHALL be accepted, so the back-to-back throughput is one result per WIDTH+2 cycles.
REQ-022 With WIDTH=1, diff and borrow_out SHALL equal the full-subtractor truth table for (a, b, borrow_in).
REQ-023 Changes on a, b or borrow_in after acceptance SHALL have no effect on the result.

Reset
REQ-024 While rst=1 at an edge, the FSM SHALL go to IDLE, and busy, done, diff, borrow_out, the counter, the borrow flop and the operand registers SHALL all be 0.
REQ-025 rst SHALL take priority over start.
REQ-026 A reset during SHIFT SHALL abort the operation with no done pulse, and the next start SHALL run normally.

Structure
REQ-027 The state encodings (IDLE=2'd0, SHIFT=2'd1, DONE=2'd2) and the default WIDTH SHALL live in the team's shared constants package/include.
REQ-028 The bit step SHALL be one instance of the existing full_substractor (ports a, b, borrow, diff, borrow_out); no other sub-module is used.
REQ-029 The counter SHALL be $clog2(WIDTH+1) bits wide and the output paths SHALL be registered.

Verification
REQ-030 WIDTH=8, a=0x5A, b=0x3C, borrow_in=0, start pulse -> done 9 cycles after acceptance, diff=0x1E, borrow_out=0.
REQ-031 a=0x00, b=0x01, borrow_in=0 -> diff=0xFF, borrow_out=1; a=0x80, b=0x7F, borrow_in=1 -> diff=0x00, borrow_out=0.
REQ-032 A second start with different operands at cycle 3 of SHIFT -> ignored; the first result is unchanged and only one done pulse occurs.
REQ-033 rst=1 at cycle 4 of SHIFT -> all outputs 0 and no done; then a=0xFF, b=0xFF, borrow_in=1 -> diff=0xFF, borrow_out=1.
REQ-034 Back-to-back starts held high continuously -> done pulses every 10 cycles; diff and borrow_out are stable while busy.
REQ-035 A WIDTH=1 instance swept over all 8 input combinations -> outputs match the full-subtractor truth table.
